// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// ASCII read-command parser between uart_rx and the QSPI flash read sequencer.
// Accepts commands of the form  'R' AAAAAA LL <CR|LF>  (hex, either case),
// turns them into one absolute read request (BASE_ADDR + AAAAAA, LL bytes with
// 00 meaning 256) and flags malformed input or inter-character timeouts.
//
// Ports:
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   rx_valid   in   uart_rx holds a byte
//   rx_data    in   received byte (meaningful while rx_valid=1)
//   rx_read    out  one-cycle consume pulse back to uart_rx
//   cmd_valid  out  read request pending
//   cmd_ready  in   downstream accepts the request
//   cmd_addr   out  BASE_ADDR + parsed address (24-bit wrap)
//   cmd_len    out  byte count 1..256
//   err        out  one-cycle error strobe
//   err_code   out  0 BAD_CMD, 1 BAD_HEX, 2 NO_TERM, 3 TIMEOUT (held until next err)
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter logic [23:0] BASE_ADDR = 24'h400000,
  parameter int unsigned TIMEOUT   = 32'd7_200_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_read,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [23:0] cmd_addr,
  output logic [8:0]  cmd_len,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LEN   = 3'd2,
    ST_TERM  = 3'd3,
    ST_ISSUE = 3'd4
  } state_t;

  localparam logic [1:0]  ERR_BAD_CMD = 2'd0;
  localparam logic [1:0]  ERR_BAD_HEX = 2'd1;
  localparam logic [1:0]  ERR_NO_TERM = 2'd2;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd3;

  // The expiry compare is against TIMEOUT-1 so that the error strobe appears
  // exactly TIMEOUT cycles after the consume pulse of the last byte.
  localparam logic        TMO_EN   = (TIMEOUT != 32'd0);
  localparam logic [31:0] TMO_LAST = TIMEOUT - 32'd1;

  // Returns {valid, nibble} for an ASCII hex digit, valid=0 otherwise.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] res;
    if ((b >= 8'h30) && (b <= 8'h39)) begin
      res = {1'b1, b[3:0]};
    end else if (((b >= 8'h41) && (b <= 8'h46)) || ((b >= 8'h61) && (b <= 8'h66))) begin
      res = {1'b1, b[3:0] + 4'd9};
    end else begin
      res = 5'd0;
    end
    return res;
  endfunction

  function automatic logic is_r(input logic [7:0] b);
    return (b == 8'h52) || (b == 8'h72);
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  state_t      state_q, state_d;
  logic        rx_read_q, rx_read_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [23:0] cmd_addr_q, cmd_addr_d;
  logic [8:0]  cmd_len_q, cmd_len_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  dig_q, dig_d;
  logic [31:0] tmo_q, tmo_d;

  logic        take_s;
  logic        busy_s;
  logic        tmo_exp_s;
  logic [4:0]  hex_s;

  // Byte acceptance, parse progress and timeout status for this cycle.
  always_comb begin
    // The !rx_read_q guard keeps a byte from being taken twice while uart_rx
    // is still dropping rx_valid; in ISSUE bytes stay buffered upstream.
    take_s    = rx_valid && !rx_read_q && (state_q != ST_ISSUE);
    busy_s    = (state_q == ST_ADDR) || (state_q == ST_LEN) || (state_q == ST_TERM);
    tmo_exp_s = TMO_EN && (tmo_q == TMO_LAST);
    hex_s     = hex_decode(rx_data);
  end

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state_q;
    rx_read_d   = take_s;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    addr_d      = addr_q;
    len_d       = len_q;
    dig_d       = dig_q;
    tmo_d       = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          if (is_r(rx_data)) begin
            addr_d  = 24'd0;
            len_d   = 8'd0;
            dig_d   = 3'd0;
            state_d = ST_ADDR;
          end else if (is_eol(rx_data) || (rx_data == 8'h20)) begin
            state_d = ST_IDLE;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_CMD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR, ST_LEN: begin
        if (take_s) begin
          if (hex_s[4]) begin
            if (state_q == ST_ADDR) begin
              addr_d = {addr_q[19:0], hex_s[3:0]};
              if (dig_q == 3'd5) begin
                dig_d   = 3'd0;
                state_d = ST_LEN;
              end else begin
                dig_d = dig_q + 3'd1;
              end
            end else begin
              len_d = {len_q[3:0], hex_s[3:0]};
              if (dig_q == 3'd1) begin
                dig_d   = 3'd0;
                state_d = ST_TERM;
              end else begin
                dig_d = dig_q + 3'd1;
              end
            end
          end else if (is_r(rx_data)) begin
            // A stray 'R' most likely starts a fresh command: flag the broken
            // one but resynchronise on the new start character.
            err_d      = 1'b1;
            err_code_d = ERR_BAD_HEX;
            addr_d     = 24'd0;
            len_d      = 8'd0;
            dig_d      = 3'd0;
            state_d    = ST_ADDR;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_HEX;
            dig_d      = 3'd0;
            state_d    = ST_IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_TERM: begin
        if (take_s) begin
          if (is_eol(rx_data)) begin
            cmd_addr_d  = BASE_ADDR + addr_q;
            cmd_len_d   = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NO_TERM;
            state_d    = ST_IDLE;
          end
        end else begin
          state_d = ST_TERM;
        end
      end

      ST_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cmd_valid_d = 1'b1;
        end
      end

      default: begin
        cmd_valid_d = 1'b0;
        dig_d       = 3'd0;
        state_d     = ST_IDLE;
      end
    endcase

    // Inter-character timer: runs only while a command is being collected
    // and no byte arrives; an accepted byte in the expiry cycle wins.
    if (busy_s && !take_s) begin
      if (tmo_exp_s) begin
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
        dig_d      = 3'd0;
        state_d    = ST_IDLE;
        tmo_d      = 32'd0;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end else begin
      tmo_d = 32'd0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rx_read_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= BASE_ADDR;
      cmd_len_q   <= 9'd1;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      addr_q      <= 24'd0;
      len_q       <= 8'd0;
      dig_q       <= 3'd0;
      tmo_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      rx_read_q   <= rx_read_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      dig_q       <= dig_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rx_read   = rx_read_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Directed bench for uart_cmd_parser. The stimulus thread pushes the expected
// read requests and error codes into queues as it sends bytes; a monitor on
// the falling clock edge pops and compares whenever the DUT completes a
// request handshake or strobes err.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

  localparam logic [23:0] BASE = 24'h400000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_read;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        err;
  logic [1:0]  err_code;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [32:0] exp_cmd_q[$];  // {len, addr}
  logic [1:0]  exp_err_q[$];

  int cyc           = 0;
  int read_cnt      = 0;
  int valid_cnt     = 0;
  int err_cnt       = 0;
  int last_read_cyc = 0;
  int last_err_cyc  = 0;

  uart_cmd_parser #(
    .BASE_ADDR(BASE),
    .TIMEOUT  (32'd100)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_read  (rx_read),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [23:0] addr, input logic [8:0] len);
    exp_cmd_q.push_back({len, addr});
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_err_q.push_back(code);
  endtask

  // Scoreboard monitor: compares on each handshake and each err strobe.
  always @(negedge clk) begin
    if (rstn) begin
      if (rx_read) begin
        read_cnt++;
        last_read_cyc = cyc;
      end
      if (cmd_valid) valid_cnt++;
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          vec_cnt++;
          miss_cnt++;
          $display("FAIL cmd_unexpected: got addr %0h len %0d with no request expected", cmd_addr, cmd_len);
        end else begin
          logic [32:0] e;
          e = exp_cmd_q.pop_front();
          check("cmd_addr", {8'd0, cmd_addr}, {8'd0, e[23:0]});
          check("cmd_len", {23'd0, cmd_len}, {23'd0, e[32:24]});
        end
      end
      if (err) begin
        err_cnt++;
        last_err_cyc = cyc;
        if (exp_err_q.size() == 0) begin
          vec_cnt++;
          miss_cnt++;
          $display("FAIL err_unexpected: got err code %0d with no error expected", err_code);
        end else begin
          logic [1:0] ec;
          ec = exp_err_q.pop_front();
          check("err_code", {30'd0, err_code}, {30'd0, ec});
        end
      end
    end
  end

  // Wait (bounded) for the consume pulse of the byte on rx_data, then drop it.
  task automatic wait_read();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_read) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL byte_consume: got no rx_read for byte %0h expected a pulse within 200 cycles", rx_data);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    wait_read();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_read"}, {31'd0, rx_read}, 32'd0);
    check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    check({tag, "_cmd_addr"}, {8'd0, cmd_addr}, 32'h0040_0000);
    check({tag, "_cmd_len"}, {23'd0, cmd_len}, 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no end of test expected finish before 500000 ns");
    $fatal(1);
  end

  initial begin
    int bad;
    int e0;
    rstn      = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b1;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rstn = 1'b1;

    // Basic command, ready held high.
    read_cnt  = 0;
    valid_cnt = 0;
    push_cmd(24'h400010, 9'd8);
    send_str("R000010");
    send_str("08");
    send_byte(8'h0D);
    repeat (4) @(negedge clk);
    check("t1_rx_read_pulses", read_cnt, 32'd10);
    check("t1_valid_cycles", valid_cnt, 32'd1);

    // Address wrap, length 00 -> 256, backpressure with bytes waiting.
    cmd_ready = 1'b0;
    send_str("RFFFFFF00");
    send_byte(8'h0A);
    rx_data  = 8'h52;
    rx_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(cmd_valid && (cmd_addr == 24'h3FFFFF) && (cmd_len == 9'd256) && !rx_read)) bad++;
    end
    check("t2_issue_hold_bad_cycles", bad, 32'd0);
    push_cmd(24'h3FFFFF, 9'd256);
    cmd_ready = 1'b1;
    wait_read();
    push_cmd(24'h500000, 9'd1);
    send_str("1");
    send_str("00000");
    send_str("01");
    send_byte(8'h0D);

    // Bad hex digit, then a clean command.
    push_err(2'd1);
    send_str("R12G");
    push_cmd(24'h400000, 9'd1);
    send_str("R00000001");
    send_byte(8'h0D);

    // Bad start byte, resync on a second 'R'.
    push_err(2'd0);
    send_str("x");
    push_err(2'd1);
    send_str("R0000R000020");
    push_cmd(24'h400020, 9'd4);
    send_str("04");
    send_byte(8'h0D);

    // Inter-character timeout.
    push_err(2'd3);
    e0 = err_cnt;
    send_str("R00");
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      #1;
      if (err_cnt != e0) break;
    end
    check("t5_timeout_seen", err_cnt - e0, 32'd1);
    check("t5_timeout_gap", last_err_cyc - last_read_cyc, 32'd100);

    // Missing terminator.
    push_err(2'd2);
    send_str("R00000001Z");
    repeat (2) @(negedge clk);
    check("t5_err_code_held", {30'd0, err_code}, 32'd2);

    // Asynchronous reset mid-address.
    send_str("R12");
    #3;
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_addr");
    @(negedge clk);
    rstn = 1'b1;

    // Asynchronous reset while a request is pending.
    cmd_ready = 1'b0;
    send_str("R00010010");
    send_byte(8'h0D);
    check("t6_issue_before_rst", {31'd0, cmd_valid}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_issue");
    @(negedge clk);
    rstn = 1'b1;
    cmd_ready = 1'b1;

    // Leading space dropped, lowercase command and hex digits.
    push_cmd(24'h40ABCD, 9'd255);
    send_str(" r00abcdff");
    send_byte(8'h0A);
    repeat (5) @(negedge clk);

    check("end_cmd_queue_empty", exp_cmd_q.size(), 32'd0);
    check("end_err_queue_empty", exp_err_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
